// File: rtl/pcg_pkg.sv
// pcg_pkg: shared PCG32 constants and helpers (XSH-RR permutation, per-channel increment).
package pcg_pkg;

    localparam logic [63:0] MULT = 64'h5851F42D4C957F2D;

    function automatic logic [31:0] xsh_rr(input logic [63:0] s);
        logic [31:0] x;
        logic [4:0]  r;
        logic [63:0] xx;
        x  = 32'(((s >> 18) ^ s) >> 27);
        r  = s[63:59];
        // rotate-right via a doubled word keeps r=0 free of a 32-bit shift
        xx = {x, x} >> r;
        return xx[31:0];
    endfunction

    function automatic logic [63:0] chan_inc(input logic [63:0] base, input int c);
        return (base + 64'(2 * c)) | 64'd1;
    endfunction

endpackage

// File: rtl/pcg_lane.sv
// pcg_lane: one PCG32 stream -- 64-bit state, Weyl or LCG step, registered output slice.
module pcg_lane
    import pcg_pkg::*;
#(
    parameter int          USE_MULT = 0,
    parameter int          OUT_W    = 6,
    parameter logic [63:0] INC_C    = 64'h1,
    parameter logic [63:0] SEED     = 64'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              step,
    input  logic [63:0]       base,
    output logic [OUT_W-1:0]  data
);

    logic [63:0] state;
    logic [63:0] state_next;

    always_comb begin
        state_next = (USE_MULT != 0) ? state * MULT + INC_C : state + INC_C;
    end

    // output is permuted from the pre-step state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED + INC_C;
            data  <= '0;
        end else if (init) begin
            state <= base + INC_C;
        end else if (step) begin
            state <= state_next;
            data  <= OUT_W'(xsh_rr(state) >> (32 - OUT_W));
        end
    end

endmodule

// File: rtl/pcg_noise_gen.sv
// pcg_noise_gen: multi-channel PCG32 noise source with runtime seed load and frame-locked replay.
module pcg_noise_gen
    import pcg_pkg::*;
#(
    parameter int          CHANNELS = 1,
    parameter int          OUT_W    = 6,
    parameter int          USE_MULT = 0,
    parameter logic [63:0] SEED     = 64'h0,
    parameter logic [63:0] INC      = 64'h14057B7EF767814
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       advance,
    input  logic                       frame_start,
    input  logic                       locked,
    input  logic                       seed_load,
    input  logic [63:0]                seed_data,
    output logic                       rnd_valid,
    output logic [CHANNELS*OUT_W-1:0]  rnd_data
);

    logic [63:0] seed_reg;
    logic [63:0] base;
    logic        init;
    logic        step;

    // seed load outranks relock, both outrank (and drop) advance
    always_comb begin
        init = seed_load | (frame_start & locked);
        base = seed_load ? seed_data : seed_reg;
        step = advance & ~init;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_reg  <= SEED;
            rnd_valid <= 1'b0;
        end else begin
            if (seed_load)
                seed_reg <= seed_data;
            rnd_valid <= step;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        pcg_lane #(
            .USE_MULT (USE_MULT),
            .OUT_W    (OUT_W),
            .INC_C    (chan_inc(INC, c)),
            .SEED     (SEED)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .init  (init),
            .step  (step),
            .base  (base),
            .data  (rnd_data[c*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_pcg_noise_gen.sv
// tb_pcg_noise_gen: scoreboard bench driving an additive 1x32 instance and a multiply 4x6 instance in lockstep.
module tb_pcg_noise_gen;

    localparam logic [63:0] M_MULT = 64'h5851F42D4C957F2D;
    localparam logic [63:0] B_INC  = 64'h14057B7EF767814;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        advance = 1'b0;
    logic        frame_start = 1'b0;
    logic        locked = 1'b0;
    logic        seed_load = 1'b0;
    logic [63:0] seed_data = '0;
    logic        va, vb;
    logic [31:0] da;
    logic [23:0] db;

    pcg_noise_gen #(.CHANNELS(1), .OUT_W(32), .USE_MULT(0), .SEED(64'h0), .INC(64'h1)) dut_a (
        .clk(clk), .rst_n(rst_n), .advance(advance), .frame_start(frame_start), .locked(locked),
        .seed_load(seed_load), .seed_data(seed_data), .rnd_valid(va), .rnd_data(da)
    );

    pcg_noise_gen #(.CHANNELS(4), .OUT_W(6), .USE_MULT(1), .SEED(64'h0), .INC(B_INC)) dut_b (
        .clk(clk), .rst_n(rst_n), .advance(advance), .frame_start(frame_start), .locked(locked),
        .seed_load(seed_load), .seed_data(seed_data), .rnd_valid(vb), .rnd_data(db)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [23:0] b;
    } exp_t;

    exp_t        q[$];
    exp_t        last;
    logic [63:0] ms_a, mseed;
    logic [63:0] ms_b[4];
    logic [63:0] inc_b[4];
    logic        mvalid;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] perm(input logic [63:0] s);
        logic [31:0] x;
        int          r;
        x = 32'(((s >> 18) ^ s) >> 27);
        r = int'(s[63:59]);
        return (r == 0) ? x : ((x >> r) | (x << (32 - r)));
    endfunction

    task automatic model_reset();
        mseed  = 64'h0;
        ms_a   = 64'h1;
        for (int c = 0; c < 4; c++) begin
            inc_b[c] = (B_INC + 64'(2 * c)) | 64'd1;
            ms_b[c]  = inc_b[c];
        end
        mvalid = 1'b0;
        q.delete();
        last.a = '0;
        last.b = '0;
    endtask

    task automatic cyc(input logic sl, input logic fs, input logic lk, input logic adv, input logic [63:0] sd);
        exp_t        e;
        logic [31:0] p;
        seed_load   = sl;
        frame_start = fs;
        locked      = lk;
        advance     = adv;
        seed_data   = sd;
        mvalid      = 1'b0;
        if (sl || (fs && lk)) begin
            if (sl)
                mseed = sd;
            ms_a = mseed + 64'h1;
            for (int c = 0; c < 4; c++)
                ms_b[c] = mseed + inc_b[c];
        end else if (adv) begin
            e.a = perm(ms_a);
            e.b = '0;
            for (int c = 0; c < 4; c++) begin
                p = perm(ms_b[c]);
                e.b[c*6 +: 6] = p[31:26];
                ms_b[c] = ms_b[c] * M_MULT + inc_b[c];
            end
            ms_a   = ms_a + 64'h1;
            mvalid = 1'b1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        check("valid_a", 64'(va), 64'(mvalid));
        check("valid_b", 64'(vb), 64'(mvalid));
        if (va) begin
            if (q.size() == 0)
                check("queue_underflow", 64'(q.size()), 64'd1);
            else
                last = q.pop_front();
        end
        check("data_a", 64'(da), 64'(last.a));
        check("data_b", 64'(db), 64'(last.b));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic adv_n(input int n, input logic lk);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, lk, 1'b1, 64'h0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_valid", 64'(va), 64'd0);
        check("rst_data_a", 64'(da), 64'd0);
        check("rst_data_b", 64'(db), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // known values from the additive single-channel stream
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h7FFFFFFF);
        adv_n(1, 1'b0);
        check("known_w0", 64'(da), 64'h10);
        adv_n(1, 1'b0);
        check("known_w1", 64'(da), 64'h10);
        idle(2);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h07FFFFFFFFFFFFFF);
        adv_n(1, 1'b0);
        check("rotate", 64'(da), 64'h2000);
        idle(1);

        // frame-locked replay, then free-running with frame_start ignored
        adv_n(100, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        adv_n(100, 1'b1);
        adv_n(100, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        adv_n(100, 1'b0);

        // all commands at once: seed load wins, advance dropped
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 64'h123456789ABCDEF0);
        check("prio_valid", 64'(va), 64'd0);
        adv_n(3, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'h0);
        adv_n(2, 1'b1);

        // long multiply run with an asynchronous reset in the middle
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            adv_n(1, 1'b0);
            if (i == 500) begin
                #1;
                rst_n = 1'b0;
                #1;
                check("async_valid", 64'(vb), 64'd0);
                check("async_data_b", 64'(db), 64'd0);
                check("async_data_a", 64'(da), 64'd0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        idle(2);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
